// File: rtl/popcnt_threshold_accum.sv
// popcnt_threshold_accum: sums NUM_CHUNKS chunk popcounts into a frame total,
// saturating at the accumulator width, and reports total >= threshold per frame.
module popcnt_threshold_accum #(
    parameter int unsigned NUM_CHUNKS = 8,
    parameter int unsigned ACC_W      = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_sum,
    input  logic             in_cy,
    input  logic [ACC_W-1:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [ACC_W-1:0] out_acc,
    output logic             busy
);

    localparam int unsigned IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [ACC_W-1:0]   acc_q, acc_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [ACC_W-1:0]   thr_q, thr_n;
    logic               out_bit_n;
    logic [ACC_W-1:0]   out_acc_n;

    logic               accept;
    logic [ACC_W-1:0]   cnt_ext;
    logic [SUM_W-1:0]   sum_wide;
    logic [ACC_W-1:0]   acc_sat;

    // A pending result blocks input unless it retires in the same cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Chunk count widened, and the saturating running sum
    assign cnt_ext  = ACC_W'({in_cy, in_sum});
    assign sum_wide = {1'b0, acc_q} + SUM_W'({in_cy, in_sum});
    assign acc_sat  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

    // Next-state and datapath update; clr overrides every handshake
    always_comb begin
        state_n   = state_q;
        acc_n     = acc_q;
        idx_n     = idx_q;
        thr_n     = thr_q;
        out_bit_n = out_bit;
        out_acc_n = out_acc;

        if (clr) begin
            state_n = IDLE;
            acc_n   = '0;
            idx_n   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        // First chunk of a frame: restart sum, latch threshold
                        acc_n = cnt_ext;
                        thr_n = threshold;
                        if (NUM_CHUNKS == 1) begin
                            state_n   = DONE;
                            idx_n     = '0;
                            out_acc_n = cnt_ext;
                            out_bit_n = (cnt_ext >= threshold);
                        end else begin
                            state_n = ACCUM;
                            idx_n   = IDX_W'(1);
                        end
                    end else if (state_q == DONE && out_ready) begin
                        state_n = IDLE;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_n = acc_sat;
                        if (idx_q == LAST_IDX) begin
                            state_n   = DONE;
                            idx_n     = '0;
                            out_acc_n = acc_sat;
                            out_bit_n = (acc_sat >= thr_q);
                        end else begin
                            idx_n = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    acc_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            thr_q     <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_acc   <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_n;
            acc_q     <= acc_n;
            idx_q     <= idx_n;
            thr_q     <= thr_n;
            out_valid <= (state_n == DONE);
            out_bit   <= out_bit_n;
            out_acc   <= out_acc_n;
            busy      <= (state_n == ACCUM);
        end
    end

endmodule

// File: tb/tb_popcnt_threshold_accum.sv
// Testbench: three instances (default, 8-bit saturating, single-chunk) checked
// every cycle against a frame-level arithmetic model, plus directed end checks.
module tb_popcnt_threshold_accum;

    logic       clk, rst_n, clr, in_valid, out_ready, in_cy;
    logic [4:0] in_sum;
    logic [8:0] thr_in;

    logic       rdy0, ov0, ob0, bsy0;
    logic [8:0] acc0;
    logic       rdy1, ov1, ob1, bsy1;
    logic [7:0] acc1;
    logic       rdy2, ov2, ob2, bsy2;
    logic [8:0] acc2;

    int vectors = 0;
    int errors  = 0;

    // Frame-level model per instance
    int m_sum[3], m_cnt[3], m_thr[3], m_acc[3];
    bit m_valid[3], m_bit[3];

    popcnt_threshold_accum #(.NUM_CHUNKS(8), .ACC_W(9)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
        .in_sum(in_sum), .in_cy(in_cy), .threshold(thr_in), .out_valid(ov0),
        .out_ready(out_ready), .out_bit(ob0), .out_acc(acc0), .busy(bsy0));

    popcnt_threshold_accum #(.NUM_CHUNKS(8), .ACC_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .in_sum(in_sum), .in_cy(in_cy), .threshold(thr_in[7:0]), .out_valid(ov1),
        .out_ready(out_ready), .out_bit(ob1), .out_acc(acc1), .busy(bsy1));

    popcnt_threshold_accum #(.NUM_CHUNKS(1), .ACC_W(9)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
        .in_sum(in_sum), .in_cy(in_cy), .threshold(thr_in), .out_valid(ov2),
        .out_ready(out_ready), .out_bit(ob2), .out_acc(acc2), .busy(bsy2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int nch(input int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic int maxv(input int i);
        return (i == 1) ? 255 : 511;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_thr[i] = 0; m_acc[i] = 0;
            m_valid[i] = 1'b0; m_bit[i] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge with the inputs that were presented
    task automatic model_step(input bit v, input int c, input bit ordy, input bit cl, input int thr);
        bit take;
        for (int i = 0; i < 3; i++) begin
            if (cl) begin
                m_valid[i] = 1'b0; m_sum[i] = 0; m_cnt[i] = 0;
            end else begin
                take = v && (!m_valid[i] || ordy);
                if (m_valid[i] && ordy) m_valid[i] = 1'b0;
                if (take) begin
                    if (m_cnt[i] == 0) m_thr[i] = thr % (maxv(i) + 1);
                    m_sum[i] += c;
                    m_cnt[i]++;
                    if (m_cnt[i] == nch(i)) begin
                        m_acc[i]   = (m_sum[i] > maxv(i)) ? maxv(i) : m_sum[i];
                        m_bit[i]   = (m_acc[i] >= m_thr[i]);
                        m_valid[i] = 1'b1;
                        m_sum[i]   = 0;
                        m_cnt[i]   = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input logic rdy, input logic ov, input logic bsy,
                              input logic ob, input logic [31:0] acc);
        chk($sformatf("i%0d_in_ready", i), 32'(rdy), 32'(!m_valid[i] || out_ready));
        chk($sformatf("i%0d_out_valid", i), 32'(ov), 32'(m_valid[i]));
        chk($sformatf("i%0d_busy", i), 32'(bsy), 32'(m_cnt[i] > 0));
        chk($sformatf("i%0d_out_bit", i), 32'(ob), 32'(m_bit[i]));
        chk($sformatf("i%0d_out_acc", i), acc, 32'(m_acc[i]));
    endtask

    task automatic check_all();
        check_inst(0, rdy0, ov0, bsy0, ob0, 32'(acc0));
        check_inst(1, rdy1, ov1, bsy1, ob1, 32'(acc1));
        check_inst(2, rdy2, ov2, bsy2, ob2, 32'(acc2));
    endtask

    // One clock cycle: drive at negedge, check before posedge, update model
    task automatic cyc(input bit v, input logic [5:0] c, input bit ordy, input bit cl);
        in_valid  = v;
        in_sum    = c[4:0];
        in_cy     = c[5];
        out_ready = ordy;
        clr       = cl;
        #1;
        check_all();
        @(posedge clk);
        model_step(v, int'(c), ordy, cl, int'(thr_in));
        @(negedge clk);
    endtask

    // Asynchronous reset pulse with random inputs, checked before any clock edge
    task automatic rst_pulse();
        in_valid  = 1'($urandom);
        in_sum    = 5'($urandom);
        in_cy     = 1'($urandom);
        out_ready = 1'($urandom);
        clr       = 1'($urandom);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        clr   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sum = '0; in_cy = 1'b0; thr_in = '0;
        model_reset();

        // Reset asserted before the first clock edge
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'($urandom);
        in_sum    = 5'($urandom);
        in_cy     = 1'($urandom);
        out_ready = 1'($urandom);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Full frame of 63s, threshold below and above the total
        thr_in = 9'd300;
        for (int k = 0; k < 8; k++) cyc(1'b1, 6'd63, 1'b1, 1'b0);
        chk("t2_valid", 32'(ov0), 32'd1);
        chk("t2_acc", 32'(acc0), 32'd504);
        chk("t2_bit", 32'(ob0), 32'd1);
        thr_in = 9'd505;
        for (int k = 0; k < 8; k++) cyc(1'b1, 6'd63, 1'b1, 1'b0);
        chk("t2b_acc", 32'(acc0), 32'd504);
        chk("t2b_bit", 32'(ob0), 32'd0);

        // Backpressure with input pending, then simultaneous retire + accept
        cyc(1'b0, 6'd0, 1'b1, 1'b1);
        thr_in = 9'd28;
        for (int k = 0; k < 8; k++) cyc(1'b1, 6'(k), 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 6'd5, 1'b0, 1'b0);
        chk("t3_ready", 32'(rdy0), 32'd0);
        chk("t3_acc", 32'(acc0), 32'd28);
        chk("t3_bit", 32'(ob0), 32'd1);
        cyc(1'b1, 6'd9, 1'b1, 1'b0);
        chk("t3_busy", 32'(bsy0), 32'd1);
        chk("t3_retired", 32'(ov0), 32'd0);

        // clr mid-frame drops the partial frame and the chunk in the clr cycle
        cyc(1'b0, 6'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b1, 6'd10, 1'b1, 1'b0);
        cyc(1'b1, 6'd20, 1'b1, 1'b1);
        chk("t4_clr_busy", 32'(bsy0), 32'd0);
        for (int k = 0; k < 8; k++) cyc(1'b1, 6'd1, 1'b1, 1'b0);
        chk("t4_acc", 32'(acc0), 32'd8);
        chk("t4_valid", 32'(ov0), 32'd1);

        // Reset mid-frame behaves the same way
        for (int k = 0; k < 5; k++) cyc(1'b1, 6'd10, 1'b1, 1'b0);
        rst_pulse();
        for (int k = 0; k < 8; k++) cyc(1'b1, 6'd1, 1'b1, 1'b0);
        chk("t4r_acc", 32'(acc0), 32'd8);
        chk("t4r_valid", 32'(ov0), 32'd1);

        // Threshold sampled on chunk 1 only
        cyc(1'b0, 6'd0, 1'b1, 1'b1);
        thr_in = 9'd100;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) thr_in = 9'd0;
            cyc(1'b1, (k < 6) ? 6'd7 : 6'd4, 1'b1, 1'b0);
        end
        chk("t5_acc", 32'(acc0), 32'd50);
        chk("t5_bit", 32'(ob0), 32'd0);

        // Saturation on the 8-bit instance; single-chunk frames
        cyc(1'b0, 6'd0, 1'b1, 1'b1);
        thr_in = 9'd255;
        for (int k = 0; k < 8; k++) cyc(1'b1, 6'd63, 1'b1, 1'b0);
        chk("t6_sat_acc", 32'(acc1), 32'd255);
        chk("t6_sat_bit", 32'(ob1), 32'd1);
        chk("t6_one_valid", 32'(ov2), 32'd1);
        chk("t6_one_acc", 32'(acc2), 32'd63);
        chk("t6_one_bit", 32'(ob2), 32'd0);

        // Randomized traffic with backpressure, clr and threshold changes
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) thr_in = 9'($urandom_range(0, 520));
            cyc(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
        end
        rst_pulse();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
